fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register feeding the decoder/controlUnit.
//   Holds the PC and drives a synchronous instruction ROM. Captures instruction, PC and a valid bit
//   for decode, and exposes the 4-bit opcode for controlUnit.
//   Resolves branches from EX (beq/bgt/blt/b + flagN/flagZ) into PC redirects and flushes the wrong path.
//   Stops fetching on a HALT opcode.
// PARAMETERS
//   ADDR_W   8      instruction word-address width; PC wraps modulo 2**ADDR_W
//   INSTR_W  32     instruction width; opcode = instr[INSTR_W-1 -: 4]
//   RESET_PC 0      PC loaded on reset
//   HALT_OP  4'hF   opcode that stops fetch
// PORTS
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous, active-high reset
//   stall       in   1        hazard unit: hold PC and IF/ID contents
//   br_valid    in   1        EX stage holds a branch this cycle
//   br_cond     in   4        opcode of that branch (4'b0100..4'b0111)
//   flagN       in   1        ALU negative flag for the branch
//   flagZ       in   1        ALU zero flag for the branch
//   br_target   in   ADDR_W   branch target word address
//   imem_addr   out  ADDR_W   ROM address (combinational = next_pc)
//   imem_rdata  in   INSTR_W  ROM data, 1-cycle latency: rdata(t) = mem[imem_addr(t-1)]
//   id_instr    out  INSTR_W  IF/ID instruction
//   id_pc       out  ADDR_W   IF/ID instruction address
//   id_valid    out  1        IF/ID holds a real instruction (0 = bubble)
//   id_opcode   out  4        id_instr[INSTR_W-1 -: 4], to controlUnit.opCode
//   redirect    out  1        branch taken this cycle (combinational); decode/ID-EX must flush
//   halted      out  1        state == HALT
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=FILL, id_instr=0, id_pc=0, id_valid=0, halted=0; imem_addr=RESET_PC.
//   taken: br_valid & (br_cond==0100 ? flagZ : br_cond==0101 ? !flagN&!flagZ :
//          br_cond==0110 ? flagN : br_cond==0111). Other br_cond values are never taken. redirect=taken.
//   next_pc: taken ? br_target : (stall | state!=RUN) ? pc : pc+1 (mod 2**ADDR_W). pc<=next_pc.
//     Invariant: imem_rdata in cycle t is mem[pc(t)].
//   States:
//     FILL: ROM output not yet valid. id_valid<=0. Next state RUN, pc held (unless taken).
//     RUN:  if taken: id_valid<=0 (flush), IF/ID instr/pc unchanged, pc<=br_target. Redirect beats stall.
//           elif stall: all IF/ID regs and pc hold.
//           else: id_instr<=imem_rdata, id_pc<=pc, id_valid<=1.
//             If imem_rdata opcode==HALT_OP, go to HALT after the capture; pc holds.
//     HALT: id_valid<=0 on the next non-stalled cycle, then stays 0; pc holds; halted=1.
//           A taken branch (older, in EX) cancels the halt: pc<=br_target, state<=FILL.
//   Latency: redirect at cycle t gives the first target instruction id_valid=1 at edge t+2 (FILL refill).
//     Sequential fetch gives 1 instruction per cycle, with no bubbles when stall=0.
//   PC wrap: pc 2**ADDR_W-1 -> 0 with no special handling.
//   rst mid-operation overrides everything in the same cycle, including taken and stall.
//   Outputs are registered except imem_addr, redirect and id_opcode (a decode of id_instr).
// TESTING
//   1 Reset release, ROM[i]=i+0x100 -> id_valid first 1 on 2nd edge with id_pc=0,id_instr=0x100; then pc 1,2,3 each cycle
//   2 stall=1 for 3 cycles while id_pc=5 -> id_pc/id_instr/imem_addr frozen; after release id_pc=6 next edge, none skipped
//   3 br_valid,br_cond=0100,Z=1,target=0x40 -> redirect=1, id_valid=0 next edge, id_pc=0x40 valid 2 edges later;
//     Z=0 -> no redirect, sequential
//   4 bgt N=0,Z=0 taken; blt N=0 not taken; b always taken; br_cond=0001 never taken; stall=1 with taken -> redirect wins
//   5 ROM[7]=0xF0000000 -> id_pc=7 valid once, then id_valid=0, halted=1;
//     a taken branch while halted -> halted=0, fetch resumes at target
//   6 pc=0xFF (ADDR_W=8) -> next id_pc=0x00; rst asserted mid-stream -> next edge pc=RESET_PC, id_valid=0, state FILL

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC, synchronous instruction-ROM addressing, IF/ID register,
//            branch resolution with wrong-path flush, HALT stop.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_valid,
    input  logic [3:0]         br_cond,
    input  logic               flagN,
    input  logic               flagZ,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               id_valid,
    output logic [3:0]         id_opcode,
    output logic               redirect,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_pc_inc = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               w_taken;
    logic               w_rdata_halt;
    logic [ADDR_W-1:0]  w_next_pc;

    always_comb begin
        w_taken = 1'b0;
        if (br_valid) begin
            case (br_cond)
                4'b0100: w_taken = flagZ;
                4'b0101: w_taken = !flagN && !flagZ;
                4'b0110: w_taken = flagN;
                4'b0111: w_taken = 1'b1;
                default: w_taken = 1'b0;
            endcase
        end
    end

    assign w_rdata_halt = (imem_rdata[INSTR_W-1 -: 4] == HALT_OP);

    // The PC only advances when RUN actually consumes the ROM word; keeping it
    // in lock-step with the ROM address makes rdata always equal mem[pc].
    always_comb begin
        w_next_pc = r_pc;
        if (w_taken)
            w_next_pc = br_target;
        else if (r_state == S_RUN && !stall && !w_rdata_halt)
            w_next_pc = r_pc + c_pc_inc;
    end

    assign imem_addr = rst ? RESET_PC : w_next_pc;
    assign redirect  = w_taken;
    assign id_opcode = id_instr[INSTR_W-1 -: 4];
    assign halted    = (r_state == S_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FILL;
            r_pc     <= RESET_PC;
            id_instr <= '0;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            case (r_state)
                S_FILL: begin
                    id_valid <= 1'b0;
                    r_state  <= S_RUN;
                end
                S_RUN: begin
                    if (w_taken) begin
                        id_valid <= 1'b0;
                    end else if (!stall) begin
                        id_instr <= imem_rdata;
                        id_pc    <= r_pc;
                        id_valid <= 1'b1;
                        if (w_rdata_halt)
                            r_state <= S_HALT;
                    end
                end
                S_HALT: begin
                    // An older branch still in EX overrides the halt.
                    if (w_taken) begin
                        id_valid <= 1'b0;
                        r_state  <= S_FILL;
                    end else if (!stall) begin
                        id_valid <= 1'b0;
                    end
                end
                default: begin
                    id_valid <= 1'b0;
                    r_state  <= S_FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
